biquad_seq: RTL and testbench



---
 rtl/biquad_seq_pkg.sv | 45 ++++
 rtl/biquad_mac.sv | 35 +++
 rtl/biquad_seq.sv | 77 +++++++
 tb/tb_biquad_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_seq_pkg.sv
// Shared constants for the biquad sequencer: word format, state encoding and mux select codes.
package biquad_seq_pkg;
  localparam int BQ_N = 24;
  localparam int BQ_F = 14;

  typedef enum logic [2:0] {IDLE, M1, M2, LDF, M3, M4, M5, UPD} state_t;

  // coefficient (S) selects
  localparam logic [2:0] SEL_CERO  = 3'b000;
  localparam logic [2:0] SEL_AUNO  = 3'b001;
  localparam logic [2:0] SEL_ADOS  = 3'b010;
  localparam logic [2:0] SEL_BCERO = 3'b011;
  localparam logic [2:0] SEL_BUNO  = 3'b100;
  localparam logic [2:0] SEL_BDOS  = 3'b101;
  // state operand (C) selects
  localparam logic [1:0] SEL_C_CERO = 2'b00;
  localparam logic [1:0] SEL_FK1    = 2'b01;
  localparam logic [1:0] SEL_FK2    = 2'b10;
  localparam logic [1:0] SEL_FK     = 2'b11;
  // addend (Z) selects
  localparam logic [2:0] SEL_Z_CERO = 3'b000;
  localparam logic [2:0] SEL_UK     = 3'b001;
  localparam logic [2:0] SEL_ACUM1  = 3'b011;
  localparam logic [2:0] SEL_ACUM3  = 3'b101;

  typedef struct packed {
    logic [2:0] s;
    logic [1:0] c;
    logic [2:0] z;
  } sel_t;

  function automatic sel_t sel_of(input state_t st);
    sel_t r;
    r = '{s: SEL_CERO, c: SEL_C_CERO, z: SEL_Z_CERO};
    case (st)
      M1:      r = '{s: SEL_AUNO,  c: SEL_FK1,    z: SEL_UK};
      M2:      r = '{s: SEL_ADOS,  c: SEL_FK2,    z: SEL_ACUM1};
      M3:      r = '{s: SEL_BCERO, c: SEL_FK,     z: SEL_Z_CERO};
      M4:      r = '{s: SEL_BUNO,  c: SEL_FK1,    z: SEL_ACUM3};
      M5:      r = '{s: SEL_BDOS,  c: SEL_FK2,    z: SEL_ACUM1};
      default: r = '{s: SEL_CERO,  c: SEL_C_CERO, z: SEL_Z_CERO};
    endcase
    return r;
  endfunction
endpackage

// File: rtl/biquad_mac.sv
// Combinational MAC: r = ((s*c) >>> F) + z, reduced to N bits.
// BIQUAD_SAT_EN selects clamping; otherwise the result wraps.
module biquad_mac import biquad_seq_pkg::*; #(
  parameter int N = BQ_N,
  parameter int F = BQ_F
) (
  input  logic signed [N-1:0] s,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] z,
  output logic signed [N-1:0] r
);
  logic signed [2*N-1:0] se, ce, ze, p, ps, sum;

  assign se  = {{N{s[N-1]}}, s};
  assign ce  = {{N{c[N-1]}}, c};
  assign ze  = {{N{z[N-1]}}, z};
  assign p   = se * ce;
  assign ps  = p >>> F;
  assign sum = ps + ze;

`ifdef BIQUAD_SAT_EN
  localparam logic signed [2*N-1:0] MAXV = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MINV = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  always_comb begin
    if (sum > MAXV)      r = MAXV[N-1:0];
    else if (sum < MINV) r = MINV[N-1:0];
    else                 r = sum[N-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum[2*N-1:N];
  assign r = sum[N-1:0];
`endif
endmodule

// File: rtl/biquad_seq.sv
// Biquad section sequencer: steps the external mux through the MAC schedule and holds
// the delay line, partial sums and output. Saturation option: BIQUAD_SAT_EN (in biquad_mac).
module biquad_seq import biquad_seq_pkg::*; #(
  parameter int N = BQ_N,
  parameter int F = BQ_F
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] x_in,
  input  logic signed [N-1:0] muxS,
  input  logic signed [N-1:0] muxC,
  input  logic signed [N-1:0] muxZ,
  output logic [2:0]          controlS,
  output logic [2:0]          controlZ,
  output logic [1:0]          controlC,
  output logic signed [N-1:0] fk,
  output logic signed [N-1:0] fk1,
  output logic signed [N-1:0] fk2,
  output logic signed [N-1:0] yk,
  output logic signed [N-1:0] Uk,
  output logic signed [N-1:0] acum1,
  output logic signed [N-1:0] acum2,
  output logic signed [N-1:0] acum3,
  output logic                busy,
  output logic                done
);
  state_t st;
  sel_t sel;
  logic signed [N-1:0] r;

  assign sel      = sel_of(st);
  assign controlS = sel.s;
  assign controlC = sel.c;
  assign controlZ = sel.z;
  assign busy     = (st != IDLE);

  biquad_mac #(.N(N), .F(F)) u_mac (.s(muxS), .c(muxC), .z(muxZ), .r(r));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      done  <= 1'b0;
      Uk    <= '0;
      fk    <= '0;
      fk1   <= '0;
      fk2   <= '0;
      yk    <= '0;
      acum1 <= '0;
      acum2 <= '0;
      acum3 <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          Uk <= x_in;
          st <= M1;
        end
        M1:  begin acum1 <= r;     st <= M2;  end
        M2:  begin acum2 <= r;     st <= LDF; end
        LDF: begin fk    <= acum2; st <= M3;  end
        M3:  begin acum3 <= r;     st <= M4;  end
        M4:  begin acum1 <= r;     st <= M5;  end
        M5:  begin acum2 <= r;     st <= UPD; end
        UPD: begin
          // delay line shifts only once both the recursion and the output are done
          yk   <= acum2;
          fk2  <= fk1;
          fk1  <= fk;
          done <= 1'b1;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_biquad_seq.sv
// Self-checking bench for biquad_seq: models the external mux and the filter recurrence.
module tb_biquad_seq;
  localparam int N = 24;
  localparam logic signed [N-1:0] A1 = N'(32112);
  localparam logic signed [N-1:0] A2 = N'(-15736);
  localparam logic signed [N-1:0] B0 = N'(3);
  localparam logic signed [N-1:0] B1 = N'(6);
  localparam logic signed [N-1:0] B2 = N'(3);
  localparam longint MAXL = (longint'(1) << (N-1)) - 1;
  localparam longint MINL = -(longint'(1) << (N-1));

  logic clk, reset, start, busy, done;
  logic signed [N-1:0] x_in, muxS, muxC, muxZ;
  logic [2:0] controlS, controlZ;
  logic [1:0] controlC;
  logic signed [N-1:0] fk, fk1, fk2, yk, Uk, acum1, acum2, acum3;

  int checks = 0;
  int errors = 0;
  longint m_fk1, m_fk2;

  biquad_seq #(.N(N), .F(14)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .muxS(muxS), .muxC(muxC), .muxZ(muxZ),
    .controlS(controlS), .controlZ(controlZ), .controlC(controlC),
    .fk(fk), .fk1(fk1), .fk2(fk2), .yk(yk), .Uk(Uk),
    .acum1(acum1), .acum2(acum2), .acum3(acum3),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external coefficient/state/addend multiplexer
  always_comb begin
    case (controlS)
      3'b001:  muxS = A1;
      3'b010:  muxS = A2;
      3'b011:  muxS = B0;
      3'b100:  muxS = B1;
      3'b101:  muxS = B2;
      default: muxS = '0;
    endcase
    case (controlC)
      2'b01:   muxC = fk1;
      2'b10:   muxC = fk2;
      2'b11:   muxC = fk;
      default: muxC = '0;
    endcase
    case (controlZ)
      3'b001:  muxZ = Uk;
      3'b010:  muxZ = acum2;
      3'b011:  muxZ = acum1;
      3'b101:  muxZ = acum3;
      default: muxZ = '0;
    endcase
  end

  function automatic longint red(input longint v);
`ifdef BIQUAD_SAT_EN
    if (v > MAXL) return MAXL;
    if (v < MINL) return MINL;
    return v;
`else
    logic [N-1:0] t;
    t = v[N-1:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic longint prod(input longint k, input longint v);
    return (k * v) >>> 14;
  endfunction

  task automatic model_reset();
    m_fk1 = 0;
    m_fk2 = 0;
  endtask

  // w[k] = x + a1*w[k-1] + a2*w[k-2];  y = b0*w[k] + b1*w[k-1] + b2*w[k-2]
  task automatic model_step(input longint x, output longint y, output longint f);
    longint t;
    t = red(prod(A1, m_fk1) + x);
    f = red(prod(A2, m_fk2) + t);
    t = red(prod(B0, f));
    t = red(prod(B1, m_fk1) + t);
    y = red(prod(B2, m_fk2) + t);
    m_fk2 = m_fk1;
    m_fk1 = f;
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; x_in = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // one start pulse; lat = cycles until done is seen, -1 on timeout
  task automatic send(input logic signed [N-1:0] x, output int lat);
    x_in = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic signed [N-1:0] v [8];
    v = '{fk, fk1, fk2, yk, Uk, acum1, acum2, acum3};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (v[i] !== '0) begin
        errors++; $display("FAIL %s reg%0d got %0d want 0", tag, i, v[i]);
      end
    end
    checks++;
    if ({busy, done, controlS, controlC, controlZ} !== 10'b0) begin
      errors++; $display("FAIL %s ctrl got %b want 0", tag, {busy, done, controlS, controlC, controlZ});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; x_in = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_impulse();
    longint ey, ef;
    int lat;
    longint xs [3] = '{16384, 0, 0};
    longint ry [3] = '{3, 11, 22};
    longint rf [3] = '{16384, 32112, 47202};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send(N'(xs[i]), lat);
      model_step(xs[i], ey, ef);
      checks++;
      if (lat != 8) begin errors++; $display("FAIL impulse_lat%0d got %0d want 8", i, lat); end
      checks++;
      if (yk !== N'(ry[i])) begin errors++; $display("FAIL impulse_yk%0d got %0d want %0d", i, yk, ry[i]); end
      checks++;
      if (fk !== N'(rf[i])) begin errors++; $display("FAIL impulse_fk%0d got %0d want %0d", i, fk, rf[i]); end
      checks++;
      if (yk !== N'(ey)) begin errors++; $display("FAIL impulse_model%0d got %0d want %0d", i, yk, ey); end
    end
  endtask

  task automatic test_selects();
    logic [7:0] seq [7] = '{8'b001_01_001, 8'b010_10_011, 8'b000_00_000, 8'b011_11_000,
                            8'b100_01_101, 8'b101_10_011, 8'b000_00_000};
    apply_reset();
    x_in = N'(100); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({controlS, controlC, controlZ} !== seq[i]) begin
        errors++; $display("FAIL sel%0d got %b want %b", i, {controlS, controlC, controlZ}, seq[i]);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy%0d got %b want 1", i, busy); end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    longint ey, ef;
    logic signed [N-1:0] x;
    int ndone;
    apply_reset();
    x = N'($urandom_range(0, 50000));
    x_in = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_step(x, ey, ef);
    repeat (3) begin @(posedge clk); #1; end
    x_in = N'(999); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (Uk !== x) begin errors++; $display("FAIL ignore_uk got %0d want %0d", Uk, x); end
    ndone = 0;
    repeat (20) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ignore_done got %0d want 1", ndone); end
    checks++;
    if (yk !== N'(ey)) begin errors++; $display("FAIL ignore_yk got %0d want %0d", yk, ey); end
  endtask

  task automatic test_reset_mid();
    int lat;
    apply_reset();
    x_in = N'(16384); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    send(N'(16384), lat);
    checks++;
    if (yk !== N'(3)) begin errors++; $display("FAIL reset_mid_yk got %0d want 3", yk); end
  endtask

  task automatic test_overflow();
    longint ey, ef;
    int lat;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      send(N'(MAXL), lat);
      model_step(MAXL, ey, ef);
    end
    checks++;
    if (fk !== N'(ef)) begin errors++; $display("FAIL ovf_fk got %0d want %0d", fk, ef); end
`ifdef BIQUAD_SAT_EN
    checks++;
    if (fk !== N'(MAXL)) begin errors++; $display("FAIL ovf_sat got %0d want %0d", fk, MAXL); end
`else
    checks++;
    if (fk === N'(MAXL)) begin errors++; $display("FAIL ovf_wrap got %0d want wrapped value", fk); end
`endif
  endtask

  task automatic test_random();
    longint ey, ef;
    int lat;
    logic [N-1:0] t;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      t = N'($urandom);
      if (i < 4) t = N'($signed(t) >>> 6);
      send($signed(t), lat);
      model_step(longint'($signed(t)), ey, ef);
      checks++;
      if (lat != 8) begin errors++; $display("FAIL rand_lat%0d got %0d want 8", i, lat); end
      checks++;
      if (yk !== N'(ey)) begin errors++; $display("FAIL rand_yk%0d got %0d want %0d", i, yk, ey); end
      checks++;
      if (fk !== N'(ef)) begin errors++; $display("FAIL rand_fk%0d got %0d want %0d", i, fk, ef); end
    end
  endtask

  task automatic test_back_to_back();
    longint ey, ef;
    logic signed [N-1:0] xs [3];
    int dcyc [3];
    int nd, cyc;
    apply_reset();
    for (int i = 0; i < 3; i++) xs[i] = N'($urandom_range(0, 40000));
    nd = 0; cyc = 0;
    x_in = xs[0]; start = 1'b1;
    while (nd < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        dcyc[nd] = cyc;
        model_step(xs[nd], ey, ef);
        checks++;
        if (yk !== N'(ey)) begin errors++; $display("FAIL b2b_yk%0d got %0d want %0d", nd, yk, ey); end
        nd++;
        if (nd < 3) x_in = xs[nd];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (nd != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", nd);
    end else begin
      checks++;
      if (dcyc[0] != 8) begin errors++; $display("FAIL b2b_first got %0d want 8", dcyc[0]); end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (dcyc[i] - dcyc[i-1] != 8) begin
          errors++; $display("FAIL b2b_gap%0d got %0d want 8", i, dcyc[i] - dcyc[i-1]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x_in = '0;
    test_reset();
    test_impulse();
    test_selects();
    test_ignore_start();
    test_reset_mid();
    test_overflow();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
